i2s_rx: RTL and testbench

//  I2S slave receiver upstream of the TDM transmitter. Oversamples external BCLK/LRCLK/DIN with
//  in_mclk and deserialises left/right words. Presents each stereo pair as out_frame_1/out_frame_2

---
 rtl/i2s_rx.sv | 165 ++++++++++++++++
 tb/tb_i2s_rx.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx
// I2S slave receiver. Oversamples the external BCLK/LRCLK/DIN pins with
// in_mclk, deserialises MSB-first left/right words and presents each
// complete stereo pair with a one-cycle strobe.
//
// Optional build macro: I2S_RX_ERR_EN
//   defined   : out_err pulses when a LEFT/RIGHT word ends with fewer than
//               G_BITS bits (the word is still delivered, zero-padded)
//   undefined : out_err is tied low and no check logic is built
//
// Ports
//   in_mclk          system clock, all logic on rising edge
//   in_reset         asynchronous active-high reset
//   in_bclk          I2S bit clock (asynchronous, each phase >= 2 in_mclk)
//   in_lrclk         I2S word select, 0 = left, 1 = right
//   in_din           I2S serial data
//   out_frame_1      left sample of the last complete pair
//   out_frame_2      right sample of the last complete pair
//   out_frame_strobe 1-cycle pulse, new pair valid on out_frame_1/2
//   out_err          1-cycle pulse on a short word (see macro above)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SYNC  | waiting for the first word boundary, data ignored
// ST_LEFT  | receiving a left word
// ST_RIGHT | receiving a right word; pair is emitted at its end if the
//          | left half of the pair was captured completely
module i2s_rx #(
  parameter int G_BITS = 16
) (
  input  logic              in_mclk,
  input  logic              in_reset,
  input  logic              in_bclk,
  input  logic              in_lrclk,
  input  logic              in_din,
  output logic [G_BITS-1:0] out_frame_1,
  output logic [G_BITS-1:0] out_frame_2,
  output logic              out_frame_strobe,
  output logic              out_err
);

  typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  localparam logic [6:0]        BITS_L  = 7'(G_BITS);
  localparam logic [G_BITS-1:0] MSB_ONE = {1'b1, {(G_BITS-1){1'b0}}};

  state_t            state;
  logic [1:0]        bclk_sync;
  logic [1:0]        lrclk_sync;
  logic [1:0]        din_sync;
  logic              bclk_q;
  logic              lr_prev;
  logic [5:0]        bit_cnt;
  logic [G_BITS-1:0] shreg;
  logic [G_BITS-1:0] left_hold;
  logic              left_ok;

  logic              bclk_s;
  logic              lrclk_s;
  logic              din_s;
  logic              bclk_rise;
  logic              boundary;
  logic [G_BITS-1:0] word_next;

  assign bclk_s  = bclk_sync[1];
  assign lrclk_s = lrclk_sync[1];
  assign din_s   = din_sync[1];

  // word_next is shreg with the current bit inserted; it is also the
  // completed word on a boundary rise (the I2S 1-bit delay puts the LSB
  // slot of the outgoing word on the rise where lrclk changes).
  always_comb begin
    bclk_rise = bclk_s & ~bclk_q;
    boundary  = bclk_rise & (lrclk_s != lr_prev);
    word_next = shreg;
    if (({1'b0, bit_cnt} < BITS_L) && din_s)
      word_next = shreg | (MSB_ONE >> bit_cnt);
  end

  always_ff @(posedge in_mclk or posedge in_reset) begin
    if (in_reset) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      din_sync   <= '0;
      bclk_q     <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[0], in_bclk};
      lrclk_sync <= {lrclk_sync[0], in_lrclk};
      din_sync   <= {din_sync[0], in_din};
      bclk_q     <= bclk_s;
    end
  end

  always_ff @(posedge in_mclk or posedge in_reset) begin
    if (in_reset) begin
      state            <= ST_SYNC;
      lr_prev          <= 1'b0;
      bit_cnt          <= '0;
      shreg            <= '0;
      left_hold        <= '0;
      left_ok          <= 1'b0;
      out_frame_1      <= '0;
      out_frame_2      <= '0;
      out_frame_strobe <= 1'b0;
    end else begin
      out_frame_strobe <= 1'b0;
      if (bclk_rise) begin
        lr_prev <= lrclk_s;
        if (boundary) begin
          shreg   <= '0;
          bit_cnt <= '0;
          case (state)
            ST_SYNC: begin
              state <= lrclk_s ? ST_RIGHT : ST_LEFT;
            end
            ST_LEFT: begin
              left_hold <= word_next;
              left_ok   <= 1'b1;
              state     <= ST_RIGHT;
            end
            ST_RIGHT: begin
              if (left_ok) begin
                out_frame_1      <= left_hold;
                out_frame_2      <= word_next;
                out_frame_strobe <= 1'b1;
              end
              left_ok <= 1'b0;
              state   <= ST_LEFT;
            end
            default: begin
              left_ok <= 1'b0;
              state   <= ST_SYNC;
            end
          endcase
        end else begin
          shreg <= word_next;
          if (bit_cnt != 6'd63)
            bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

`ifdef I2S_RX_ERR_EN
  // Bits received = bit_cnt + 1 (the boundary bit), so a short word is
  // bit_cnt < G_BITS - 1 at the boundary rise.
  logic err_q;
  logic short_word;

  assign short_word = ({1'b0, bit_cnt} < (BITS_L - 7'd1));

  always_ff @(posedge in_mclk or posedge in_reset) begin
    if (in_reset)
      err_q <= 1'b0;
    else
      err_q <= boundary && short_word &&
               ((state == ST_LEFT) || (state == ST_RIGHT));
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
module tb_i2s_rx;

  localparam int G = 16;
`ifdef I2S_RX_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic          in_mclk  = 1'b0;
  logic          in_reset = 1'b1;
  logic          in_bclk  = 1'b0;
  logic          in_lrclk = 1'b0;
  logic          in_din   = 1'b0;
  logic [G-1:0]  out_frame_1;
  logic [G-1:0]  out_frame_2;
  logic          out_frame_strobe;
  logic          out_err;

  i2s_rx #(.G_BITS(G)) dut (
    .in_mclk          (in_mclk),
    .in_reset         (in_reset),
    .in_bclk          (in_bclk),
    .in_lrclk         (in_lrclk),
    .in_din           (in_din),
    .out_frame_1      (out_frame_1),
    .out_frame_2      (out_frame_2),
    .out_frame_strobe (out_frame_strobe),
    .out_err          (out_err)
  );

  always #5 in_mclk = ~in_mclk;

  int          checks     = 0;
  int          passed     = 0;
  int          strobe_cnt = 0;
  int          err_cnt    = 0;
  bit          prev_strobe = 1'b0;
  logic [31:0] exp_q[$];
  int          hp = 4;
  bit          prev_bit = 1'b0;

  // Scoreboard: each strobe pops the oldest expected {left, right} pair.
  always @(negedge in_mclk) begin
    if (!in_reset) begin
      if (out_frame_strobe) begin
        strobe_cnt++;
        checks++;
        if (prev_strobe)
          $display("FAIL strobe_width: strobe high on two consecutive cycles");
        else
          passed++;
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL frame_pair: unexpected strobe got %h_%h expected none",
                   out_frame_1, out_frame_2);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if ({out_frame_1, out_frame_2} !== e)
            $display("FAIL frame_pair: got %h_%h expected %h_%h",
                     out_frame_1, out_frame_2, e[31:16], e[15:0]);
          else
            passed++;
        end
      end
      if (out_err === 1'b1) err_cnt++;
      prev_strobe = out_frame_strobe;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  // One BCLK period: lrclk and din change with the falling edge; din carries
  // the bit queued on the previous period (I2S one-bit delay).
  task automatic bclk_period(input bit lr, input bit b);
    in_bclk  = 1'b0;
    in_lrclk = lr;
    in_din   = prev_bit;
    prev_bit = b;
    repeat (hp) @(negedge in_mclk);
    in_bclk = 1'b1;
    repeat (hp) @(negedge in_mclk);
  endtask

  task automatic send_slot(input bit lr, input logic [G-1:0] w, input int len);
    for (int k = 0; k < len; k++)
      bclk_period(lr, (k < G) ? w[G-1-k] : 1'b0);
  endtask

  task automatic apply_reset(input bit lr0);
    @(negedge in_mclk);
    in_reset = 1'b1;
    in_bclk  = 1'b0;
    in_lrclk = lr0;
    in_din   = 1'b0;
    prev_bit = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge in_mclk);
    in_reset = 1'b0;
    repeat (4) @(negedge in_mclk);
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    checks++;
    if ({out_frame_1, out_frame_2} !== 32'h0)
      $display("FAIL reset_frames: got %h_%h expected 0000_0000", out_frame_1, out_frame_2);
    else passed++;
    checks++;
    if (out_frame_strobe !== 1'b0)
      $display("FAIL reset_strobe: got %b expected 0", out_frame_strobe);
    else passed++;
    checks++;
    if (out_err !== 1'b0)
      $display("FAIL reset_err: got %b expected 0", out_err);
    else passed++;
  endtask

  task automatic test_basic();
    int s0, e0;
    apply_reset(1'b0);
    hp = 4;
    s0 = strobe_cnt; e0 = err_cnt;
    send_slot(1'b0, 16'h1357, 32);
    send_slot(1'b1, 16'h2468, 32);
    exp_q.push_back({16'hA5C3, 16'h0F0F});
    send_slot(1'b0, 16'hA5C3, 32);
    send_slot(1'b1, 16'h0F0F, 32);
    exp_q.push_back({16'h1234, 16'hABCD});
    send_slot(1'b0, 16'h1234, 32);
    send_slot(1'b1, 16'hABCD, 32);
    send_slot(1'b0, 16'h0000, 4);
    repeat (40) @(negedge in_mclk);
    checks++;
    if (exp_q.size() != 0 || strobe_cnt - s0 != 2)
      $display("FAIL basic_count: got %0d strobes, %0d pending expected 2 strobes, 0 pending",
               strobe_cnt - s0, exp_q.size());
    else passed++;
    checks++;
    if ({out_frame_1, out_frame_2} !== {16'h1234, 16'hABCD})
      $display("FAIL basic_hold: got %h_%h expected 1234_abcd", out_frame_1, out_frame_2);
    else passed++;
    checks++;
    if (err_cnt - e0 != 0)
      $display("FAIL basic_err: got %0d expected 0", err_cnt - e0);
    else passed++;
  endtask

  task automatic test_mid_right();
    int s0, e0;
    apply_reset(1'b1);
    hp = 4;
    s0 = strobe_cnt; e0 = err_cnt;
    send_slot(1'b1, 16'hDEAD, 10);
    exp_q.push_back({16'h1111, 16'h2222});
    send_slot(1'b0, 16'h1111, 32);
    send_slot(1'b1, 16'h2222, 32);
    exp_q.push_back({16'h3333, 16'h4444});
    send_slot(1'b0, 16'h3333, 32);
    send_slot(1'b1, 16'h4444, 32);
    send_slot(1'b0, 16'h0000, 4);
    repeat (40) @(negedge in_mclk);
    checks++;
    if (exp_q.size() != 0 || strobe_cnt - s0 != 2)
      $display("FAIL midright_count: got %0d strobes, %0d pending expected 2 strobes, 0 pending",
               strobe_cnt - s0, exp_q.size());
    else passed++;
    checks++;
    if (err_cnt - e0 != ERR_EN)
      $display("FAIL midright_err: got %0d expected %0d", err_cnt - e0, ERR_EN);
    else passed++;
  endtask

  task automatic test_16bit_slots();
    int s0, e0;
    apply_reset(1'b0);
    hp = 4;
    s0 = strobe_cnt; e0 = err_cnt;
    send_slot(1'b0, 16'h0000, 16);
    send_slot(1'b1, 16'h0000, 16);
    exp_q.push_back({16'h8001, 16'h7FFE});
    send_slot(1'b0, 16'h8001, 16);
    send_slot(1'b1, 16'h7FFE, 16);
    exp_q.push_back({16'hFFFF, 16'h0001});
    send_slot(1'b0, 16'hFFFF, 16);
    send_slot(1'b1, 16'h0001, 16);
    send_slot(1'b0, 16'h0000, 4);
    repeat (40) @(negedge in_mclk);
    checks++;
    if (exp_q.size() != 0 || strobe_cnt - s0 != 2)
      $display("FAIL slot16_count: got %0d strobes, %0d pending expected 2 strobes, 0 pending",
               strobe_cnt - s0, exp_q.size());
    else passed++;
    checks++;
    if (err_cnt - e0 != 0)
      $display("FAIL slot16_err: got %0d expected 0", err_cnt - e0);
    else passed++;
  endtask

  task automatic test_short_word();
    int s0, e0;
    apply_reset(1'b0);
    hp = 4;
    s0 = strobe_cnt; e0 = err_cnt;
    send_slot(1'b0, 16'h0000, 32);
    send_slot(1'b1, 16'h0000, 32);
    exp_q.push_back({16'hABC0, 16'h0F0F});
    send_slot(1'b0, 16'hABC0, 12);
    send_slot(1'b1, 16'h0F0F, 32);
    checks++;
    if (err_cnt - e0 != ERR_EN)
      $display("FAIL short_err_left: got %0d expected %0d", err_cnt - e0, ERR_EN);
    else passed++;
    send_slot(1'b0, 16'h0000, 4);
    repeat (40) @(negedge in_mclk);
    checks++;
    if (exp_q.size() != 0 || strobe_cnt - s0 != 1)
      $display("FAIL short_count: got %0d strobes, %0d pending expected 1 strobe, 0 pending",
               strobe_cnt - s0, exp_q.size());
    else passed++;
    checks++;
    if (err_cnt - e0 != ERR_EN)
      $display("FAIL short_err_total: got %0d expected %0d", err_cnt - e0, ERR_EN);
    else passed++;
  endtask

  task automatic test_reset_mid_word();
    int s0, e0, s1;
    apply_reset(1'b0);
    hp = 4;
    s0 = strobe_cnt; e0 = err_cnt;
    send_slot(1'b0, 16'h0000, 32);
    send_slot(1'b1, 16'h0000, 32);
    exp_q.push_back({16'h1111, 16'h2222});
    send_slot(1'b0, 16'h1111, 32);
    send_slot(1'b1, 16'h2222, 32);
    send_slot(1'b0, 16'h5555, 32);
    checks++;
    if ({out_frame_1, out_frame_2} !== {16'h1111, 16'h2222})
      $display("FAIL rstmid_before: got %h_%h expected 1111_2222", out_frame_1, out_frame_2);
    else passed++;
    send_slot(1'b1, 16'h7777, 8);
    in_reset = 1'b1;
    #1;
    checks++;
    if ({out_frame_1, out_frame_2, out_frame_strobe, out_err} !== 34'h0)
      $display("FAIL rstmid_async: got %h_%h strobe %b err %b expected all 0",
               out_frame_1, out_frame_2, out_frame_strobe, out_err);
    else passed++;
    repeat (3) @(negedge in_mclk);
    in_reset = 1'b0;
    s1 = strobe_cnt;
    repeat (4) @(negedge in_mclk);
    send_slot(1'b1, 16'h7777, 8);
    exp_q.push_back({16'hAAAA, 16'hBBBB});
    send_slot(1'b0, 16'hAAAA, 32);
    send_slot(1'b1, 16'hBBBB, 32);
    exp_q.push_back({16'hCCCC, 16'hDDDD});
    send_slot(1'b0, 16'hCCCC, 32);
    send_slot(1'b1, 16'hDDDD, 32);
    send_slot(1'b0, 16'h0000, 4);
    repeat (40) @(negedge in_mclk);
    checks++;
    if (exp_q.size() != 0 || strobe_cnt - s1 != 2 || strobe_cnt - s0 != 3)
      $display("FAIL rstmid_count: got %0d strobes after reset, %0d pending expected 2 strobes, 0 pending",
               strobe_cnt - s1, exp_q.size());
    else passed++;
    checks++;
    if (err_cnt - e0 != ERR_EN)
      $display("FAIL rstmid_err: got %0d expected %0d", err_cnt - e0, ERR_EN);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int s0, e0;
    logic [G-1:0] l, r;
    apply_reset(1'b0);
    hp = 2;
    s0 = strobe_cnt; e0 = err_cnt;
    send_slot(1'b0, 16'h0000, 16);
    send_slot(1'b1, 16'h0000, 16);
    for (int p = 0; p < 100; p++) begin
      l = G'($urandom);
      r = G'($urandom);
      exp_q.push_back({l, r});
      send_slot(1'b0, l, 16);
      send_slot(1'b1, r, 16);
    end
    send_slot(1'b0, 16'h0000, 4);
    repeat (40) @(negedge in_mclk);
    checks++;
    if (exp_q.size() != 0 || strobe_cnt - s0 != 100)
      $display("FAIL b2b_count: got %0d strobes, %0d pending expected 100 strobes, 0 pending",
               strobe_cnt - s0, exp_q.size());
    else passed++;
    checks++;
    if (err_cnt - e0 != 0)
      $display("FAIL b2b_err: got %0d expected 0", err_cnt - e0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_right();
    test_16bit_slots();
    test_short_word();
    test_reset_mid_word();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
